xor_rotate_cipher_stage: RTL and testbench
==========================================

Name: xor_rotate_cipher_stage

Overview:
Parametrised XOR-with-rotated-key cipher stage that sits between the parallelizer and the collector. Replaces edge-triggered control with a valid/ready stream on both sides. Supports left or right key rotation per beat and buffers results in an output FIFO so the collector can stall without blocking the upstream pipeline. Key programming is an in-band beat on the same input stream, so it stays ordered with the data beats around it.

Parameters:
DATA_W, 32, width of data, key and result in bits; must be ≥2.
ROT_W, 5, width of rotation amount; must be ≥ clog2(DATA_W).
FIFO_DEPTH, 4, output FIFO entries; must be a power of 2 and ≥2.

Ports:
clk  in  1  clock, all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  upstream beat valid.
in_ready  out  1  stage can accept a beat.
in_prog  in  1  beat is a key load (1) or a data beat (0).
in_data  in  DATA_W  key (prog beat) or plaintext/ciphertext (data beat).
in_rot  in  ROT_W  rotation amount; ignored on prog beats.
in_dir  in  1  0 = rotate key left, 1 = rotate key right; ignored on prog beats.
out_valid  out  1  FIFO head valid.
out_ready  in  1  collector accepts the head.
out_data  out  DATA_W  FIFO head.
key_loaded  out  1  a key has been programmed since reset.
nokey_err  out  1  sticky: a data beat was accepted while no key was loaded.
fifo_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, active-high; clk rising-edge logic): in_ready=0 while reset is high; out_valid=0, out_data=0, key_loaded=0, nokey_err=0, fifo_count=0. Key register=0, FIFO pointers=0. Reset mid-stream discards all FIFO contents and the key.
- Accept: a beat is accepted on a rising edge where in_valid && in_ready.
- in_ready = !reset && (fifo_count < FIFO_DEPTH). This applies to prog beats too, which keeps ordering simple.
- FSM has two states: NOKEY and KEYED.
  - NOKEY -> KEYED on an accepted prog beat.
  - KEYED stays KEYED. A further prog beat replaces the key and takes effect for the next accepted data beat.
  - Only reset returns the FSM to NOKEY.
- Prog beat: key <= in_data; key_loaded <= 1; nothing is written to the FIFO.
- Data beat in KEYED:
  - r = in_rot mod DATA_W.
  - rk = rotl(key, r) if in_dir=0, otherwise rotr(key, r).
  - r=0 gives rk = key. No shift by DATA_W is ever performed.
  - Result in_data ^ rk is written to the FIFO tail on the same edge.
- Data beat in NOKEY: the beat is accepted and dropped, nokey_err <= 1 (sticky until reset), nothing is written to the FIFO.
- Latency: a data beat accepted at edge N appears with out_valid=1 after edge N, if the FIFO was empty.
- Output side:
  - out_valid = (fifo_count != 0); out_data = FIFO head, registered.
  - The head is popped on an edge where out_valid && out_ready.
  - out_data must hold stable while out_valid && !out_ready.
- Simultaneous push and pop: fifo_count is unchanged, order is preserved. When full, a pop in the same cycle does not raise in_ready until the next cycle (no pass-through).
- Pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH and never underflows.
- Cipher is symmetric: the same key, rot and dir applied to the ciphertext recover the plaintext.

Optional Feature:
ROLLING_KEY_EN:
- Defined: after each data beat processed in KEYED, key <= rk (the rotated key becomes the stored key). Prog beats still overwrite the key.
- Undefined: the key is static between prog beats.

Test Plan:
- Basic encrypt: prog 0x000000FF, then data 0x12345678 with rot=4, dir=0 -> out_data 0x12345988, one cycle after accept.
- Rotation edges: key 0x80000001.
  - rot=0 on data 0 -> 0x80000001.
  - rot=31, dir=0 -> 0xC0000000.
  - key 0x000000FF, rot=4, dir=1 -> 0xF000000F.
- Backpressure: out_ready=0, 5 data beats offered -> 4 accepted, fifo_count=4, in_ready=0. Then out_ready=1 -> 4 outputs in order, and the 5th beat is accepted once space frees.
- No key: data 0xAAAA5555 before any prog -> beat accepted, no output, nokey_err=1, key_loaded=0. A subsequent prog plus data works normally and nokey_err stays 1.
- Reset mid-operation: 3 entries queued, assert reset -> out_valid=0, fifo_count=0, key_loaded=0 immediately (async). After release, data without prog sets nokey_err.
- ROLLING_KEY_EN: prog 0x00000001, two data 0 beats with rot=1, dir=0 -> outputs 0x00000002 then 0x00000004. Without the macro -> 0x00000002 then 0x00000002.

Source files
------------

// File: rtl/xor_rotate_cipher_stage_if.sv
// Stream and status bundle for xor_rotate_cipher_stage.
// The slave side is the cipher stage and the master side is the upstream/collector pair.
interface xor_rotate_cipher_stage_if #(
  parameter int DATA_W     = 32,
  parameter int ROT_W      = 5,
  parameter int FIFO_DEPTH = 4
);
  logic                          in_valid;
  logic                          in_ready;
  logic                          in_prog;
  logic [DATA_W-1:0]             in_data;
  logic [ROT_W-1:0]              in_rot;
  logic                          in_dir;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_W-1:0]             out_data;
  logic                          key_loaded;
  logic                          nokey_err;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (
    output in_valid, in_prog, in_data, in_rot, in_dir, out_ready,
    input  in_ready, out_valid, out_data, key_loaded, nokey_err, fifo_count
  );

  modport slave (
    input  in_valid, in_prog, in_data, in_rot, in_dir, out_ready,
    output in_ready, out_valid, out_data, key_loaded, nokey_err, fifo_count
  );
endinterface

// File: rtl/xor_rotate_cipher_stage.sv
// XOR-with-rotated-key cipher stage: in-band key programming, valid/ready on both sides, output FIFO.
// Optional ROLLING_KEY_EN: each processed data beat stores its rotated key as the new key.
module xor_rotate_cipher_stage #(
  parameter int DATA_W     = 32,
  parameter int ROT_W      = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  xor_rotate_cipher_stage_if.slave     bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [0:0] ST_NOKEY = 1'b0;
  localparam logic [0:0] ST_KEYED = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic              nokey_err_q, nokey_err_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_s, accept_s, push_s, pop_s;
  logic [ROT_W-1:0]  rot_s;
  logic [DATA_W-1:0] rk_s, result_s;

  // Rotations go through a doubled word so a zero amount never needs a shift by DATA_W.
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] v, input logic [ROT_W-1:0] r);
    logic [2*DATA_W-1:0] w;
    w = {v, v} << r;
    return w[2*DATA_W-1:DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] v, input logic [ROT_W-1:0] r);
    logic [2*DATA_W-1:0] w;
    w = {v, v} >> r;
    return w[DATA_W-1:0];
  endfunction

  assign in_ready_s = !reset && (count_q < CW'(FIFO_DEPTH));
  assign accept_s   = bus.in_valid && in_ready_s;
  assign push_s     = accept_s && !bus.in_prog && (state_q == ST_KEYED);
  assign pop_s      = out_valid_q && bus.out_ready;
  assign rot_s      = ROT_W'(int'(bus.in_rot) % DATA_W);
  assign rk_s       = bus.in_dir ? rotr(key_q, rot_s) : rotl(key_q, rot_s);
  assign result_s   = bus.in_data ^ rk_s;

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.key_loaded = (state_q == ST_KEYED);
  assign bus.nokey_err  = nokey_err_q;
  assign bus.fifo_count = count_q;

  // Key FSM and sticky error next state.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    nokey_err_d = nokey_err_q;
    if (accept_s && bus.in_prog) begin
      state_d = ST_KEYED;
      key_d   = bus.in_data;
    end else if (accept_s && (state_q == ST_NOKEY)) begin
      nokey_err_d = 1'b1;
    end else if (push_s) begin
`ifdef ROLLING_KEY_EN
      key_d = rk_s;
`else
      key_d = key_q;
`endif
    end else begin
      state_d = state_q;
    end
  end

  // FIFO pointers, occupancy and the registered head value.
  always_comb begin
    wr_ptr_d    = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d    = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
    // With one entry left, the new head after a pop can only come from the concurrent push.
    if (pop_s) begin
      if (count_q > CW'(1)) begin
        out_data_d = mem_q[rd_ptr_q + PW'(1)];
      end else if (push_s) begin
        out_data_d = result_s;
      end else begin
        out_data_d = {DATA_W{1'b0}};
      end
    end else if (push_s && (count_q == CW'(0))) begin
      out_data_d = result_s;
    end else begin
      out_data_d = out_data_q;
    end
    out_valid_d = (count_d != CW'(0));
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_NOKEY;
      key_q       <= {DATA_W{1'b0}};
      nokey_err_q <= 1'b0;
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      out_data_q  <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      nokey_err_q <= nokey_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= result_s;
    end
  end
endmodule

// File: tb/tb_xor_rotate_cipher_stage.sv
// Scoreboard bench for xor_rotate_cipher_stage (32-bit data, 4-entry FIFO).
module tb_xor_rotate_cipher_stage;
  logic clk;
  logic reset;
  int checks;
  int errors;
  logic [31:0] exp_q[$];
  logic        m_keyed;
  logic [31:0] m_key;
  logic        m_err;

  xor_rotate_cipher_stage_if #(.DATA_W(32), .ROT_W(5), .FIFO_DEPTH(4)) bus();

  xor_rotate_cipher_stage #(.DATA_W(32), .ROT_W(5), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m_rot(input logic [31:0] v, input int r, input logic dir);
    logic [31:0] x;
    x = v;
    for (int i = 0; i < r; i++) begin
      x = dir ? {x[0], x[31:1]} : {x[30:0], x[31]};
    end
    return x;
  endfunction

  function automatic void model_accept(input logic prog, input logic [31:0] d, input logic [4:0] rot, input logic dir);
    logic [31:0] rk;
    if (prog) begin
      m_key   = d;
      m_keyed = 1'b1;
    end else if (!m_keyed) begin
      m_err = 1'b1;
    end else begin
      rk = m_rot(m_key, int'(rot) % 32, dir);
      exp_q.push_back(d ^ rk);
`ifdef ROLLING_KEY_EN
      m_key = rk;
`endif
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_keyed = 1'b0;
    m_key   = 32'h0;
    m_err   = 1'b0;
  endfunction

  // Output monitor: every completed output handshake is checked against the scoreboard.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got %h, required no output", bus.out_data);
      end else if (bus.out_data !== exp_q[0]) begin
        errors++;
        $display("FAIL out_data: got %h, required %h", bus.out_data, exp_q[0]);
        void'(exp_q.pop_front());
      end else begin
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic prog, input logic [31:0] d, input logic [4:0] rot, input logic dir);
    logic ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_prog  = prog;
    bus.in_data  = d;
    bus.in_rot   = rot;
    bus.in_dir   = dir;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: beat %h never accepted, required acceptance", d);
    end else begin
      model_accept(prog, d, rot, dir);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs pending, required 0", exp_q.size());
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    #3;
    check_val("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check_val("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check_val("rst_out_data", bus.out_data, 32'h0);
    check_val("rst_key_loaded", 32'(bus.key_loaded), 32'h0);
    check_val("rst_nokey_err", 32'(bus.nokey_err), 32'h0);
    check_val("rst_fifo_count", 32'(bus.fifo_count), 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_val("post_rst_in_ready", 32'(bus.in_ready), 32'h1);
  endtask

  task automatic test_basic_encrypt();
    bus.out_ready = 1'b0;
    send(1'b1, 32'h000000FF, 5'd0, 1'b0);
    check_val("prog_no_output", 32'(bus.out_valid), 32'h0);
    check_val("key_loaded", 32'(bus.key_loaded), 32'h1);
    send(1'b0, 32'h12345678, 5'd4, 1'b0);
    check_val("basic_latency_valid", 32'(bus.out_valid), 32'h1);
    check_val("basic_out_data", bus.out_data, 32'h12345988);
    repeat (2) @(posedge clk);
    #1;
    check_val("basic_hold", bus.out_data, 32'h12345988);
    bus.out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_rotation_edges();
    logic [31:0] exp_a [3];
    exp_a[0] = 32'h80000001;
    exp_a[1] = 32'hC0000000;
    exp_a[2] = 32'hF000000F;
    bus.out_ready = 1'b0;
    send(1'b1, 32'h80000001, 5'd0, 1'b0);
    send(1'b0, 32'h0, 5'd0, 1'b0);
    check_val("rot0", bus.out_data, exp_a[0]);
    send(1'b0, 32'h0, 5'd31, 1'b0);
    send(1'b1, 32'h000000FF, 5'd0, 1'b0);
    send(1'b0, 32'h0, 5'd4, 1'b1);
    check_val("rot_count3", 32'(bus.fifo_count), 32'h3);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("rot_edge_seq", bus.out_data, exp_a[i]);
      @(posedge clk);
      #1;
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    send(1'b1, 32'hA5A5_0F0F, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) send(1'b0, 32'h1000 + 32'(i), 5'(i * 3), 1'(i & 1));
    check_val("bp_count_full", 32'(bus.fifo_count), 32'h4);
    check_val("bp_in_ready_low", 32'(bus.in_ready), 32'h0);
    fork
      send(1'b0, 32'h2000, 5'd7, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1;
        check_val("bp_still_full", 32'(bus.fifo_count), 32'h4);
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    check_val("bp_count_empty", 32'(bus.fifo_count), 32'h0);
  endtask

  task automatic test_nokey();
    reset = 1'b1;
    model_reset();
    bus.out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    send(1'b0, 32'hAAAA5555, 5'd3, 1'b0);
    @(posedge clk);
    #1;
    check_val("nokey_out_valid", 32'(bus.out_valid), 32'h0);
    check_val("nokey_err", 32'(bus.nokey_err), 32'(m_err));
    check_val("nokey_key_loaded", 32'(bus.key_loaded), 32'h0);
    send(1'b1, 32'h0F0F0F0F, 5'd0, 1'b0);
    send(1'b0, 32'h12345678, 5'd8, 1'b1);
    wait_drain();
    check_val("nokey_err_sticky", 32'(bus.nokey_err), 32'h1);
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    send(1'b1, 32'h13579BDF, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) send(1'b0, 32'hFEED0000 + 32'(i), 5'(i), 1'b0);
    check_val("mid_count3", 32'(bus.fifo_count), 32'h3);
    #2;
    reset = 1'b1;
    #1;
    check_val("mid_out_valid", 32'(bus.out_valid), 32'h0);
    check_val("mid_fifo_count", 32'(bus.fifo_count), 32'h0);
    check_val("mid_key_loaded", 32'(bus.key_loaded), 32'h0);
    check_val("mid_in_ready", 32'(bus.in_ready), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(1'b0, 32'h11111111, 5'd1, 1'b0);
    @(posedge clk);
    #1;
    check_val("mid_nokey_err", 32'(bus.nokey_err), 32'h1);
    check_val("mid_no_output", 32'(bus.out_valid), 32'h0);
  endtask

  task automatic test_rolling_and_symmetry();
    logic [31:0] second;
    logic [31:0] p;
    logic [31:0] c;
`ifdef ROLLING_KEY_EN
    second = 32'h00000004;
`else
    second = 32'h00000002;
`endif
    bus.out_ready = 1'b0;
    send(1'b1, 32'h00000001, 5'd0, 1'b0);
    send(1'b0, 32'h0, 5'd1, 1'b0);
    send(1'b0, 32'h0, 5'd1, 1'b0);
    check_val("roll_first", bus.out_data, 32'h00000002);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val("roll_second", bus.out_data, second);
    wait_drain();
    p = 32'hCAFEBABE;
    c = p ^ m_rot(32'h8421_1248, 13, 1'b1);
    bus.out_ready = 1'b0;
    send(1'b1, 32'h8421_1248, 5'd0, 1'b0);
    send(1'b0, c, 5'd13, 1'b1);
    check_val("symmetric", bus.out_data, p);
    bus.out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    bit stop;
    stop = 1'b0;
    send(1'b1, $urandom, 5'd0, 1'b0);
    fork
      begin
        for (int i = 0; i < 24; i++) send(1'b0, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_prog   = 1'b0;
    bus.in_data   = 32'h0;
    bus.in_rot    = 5'd0;
    bus.in_dir    = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic_encrypt();
    test_rotation_edges();
    test_backpressure();
    test_nokey();
    test_reset_mid();
    test_rolling_and_symmetry();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
